// File: rtl/mul_share_arbiter.sv
// Shares one combinational unsigned WIDTH x WIDTH multiplier among NUM_REQ requesters.
// Define MUL_SHARE_RR_EN for round-robin arbitration; otherwise lowest index wins.
module mul_share_arbiter #(
  parameter int WIDTH       = 8,
  parameter int NUM_REQ     = 2,
  parameter int ID_W        = 1,
  parameter int CALC_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_in1,
  input  logic [NUM_REQ*WIDTH-1:0]   req_in2,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [2*WIDTH-1:0]         resp_out,
  output logic                       busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic               accept;
  logic [WIDTH-1:0]   sel1, sel2;

  logic [WIDTH-1:0]   in1_p0, in2_p0;
  logic [ID_W-1:0]    id_p0;
  logic [CNT_W-1:0]   cnt_p0;
  logic               capture;

  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    return {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  endfunction

`ifdef MUL_SHARE_RR_EN
  logic [ID_W-1:0] ptr;
  int              dist;
  int              best_dist;

  // Pick the valid requester closest to (ptr+1) going upward, wrapping at NUM_REQ.
  always_comb begin
    grant_id  = '0;
    grant_any = 1'b0;
    dist      = 0;
    best_dist = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist = (i + NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
      if (req_valid[i] && (dist < best_dist)) begin
        best_dist = dist;
        grant_id  = ID_W'(i);
        grant_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      ptr <= grant_id;
    end
  end
`else
  always_comb begin
    grant_id  = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !grant_any) begin
        grant_id  = ID_W'(i);
        grant_any = 1'b1;
      end
    end
  end
`endif

  assign grant     = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = (state == IDLE) && grant_any;

  always_comb begin
    sel1 = '0;
    sel2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel1 = req_in1[i*WIDTH +: WIDTH];
        sel2 = req_in2[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt_p0 == '0) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operands held stable across the multicycle path into the multiplier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in1_p0 <= '0;
      in2_p0 <= '0;
      id_p0  <= '0;
      cnt_p0 <= '0;
    end else if (accept) begin
      in1_p0 <= sel1;
      in2_p0 <= sel2;
      id_p0  <= grant_id;
      cnt_p0 <= CNT_W'(CALC_CYCLES - 1);
    end else if ((state == CALC) && (cnt_p0 != '0)) begin
      cnt_p0 <= cnt_p0 - 1'b1;
    end
  end

  assign capture = (state == CALC) && (cnt_p0 == '0);

  // Stage p1: product captured on the last CALC cycle and held through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_out <= '0;
      resp_id  <= '0;
    end else if (capture) begin
      resp_out <= mul_full(in1_p0, in2_p0);
      resp_id  <= id_p0;
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: three instances with CALC_CYCLES 1, 3 and 4.
module tb_mul_share_arbiter;

  logic        clk;
  logic        rst_n      [3];
  logic [1:0]  req_valid  [3];
  logic [1:0]  req_ready  [3];
  logic [15:0] req_in1    [3];
  logic [15:0] req_in2    [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [0:0]  resp_id    [3];
  logic [15:0] resp_out   [3];
  logic        busy       [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mul_share_arbiter #(
      .WIDTH(8), .NUM_REQ(2), .ID_W(1),
      .CALC_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk(clk), .rst_n(rst_n[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_in1(req_in1[g]), .req_in2(req_in2[g]),
      .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
      .resp_id(resp_id[g]), .resp_out(resp_out[g]), .busy(busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] prod;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [1:0]  valid;
    logic [7:0]  a0, b0, a1, b1;
    int          exp_id;
    logic [15:0] exp_prod;
  } vec_t;
  vec_t vt[6];

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Records the accepted operands of instance u, reading the grant from req_ready.
  task automatic push_accept(input int u, output int idx);
    sb_t e;
    logic [7:0] a, b;
    idx = -1;
    if ((req_valid[u] & req_ready[u]) == 2'b01) idx = 0;
    else if ((req_valid[u] & req_ready[u]) == 2'b10) idx = 1;
    if (idx >= 0) begin
      a = req_in1[u][idx*8 +: 8];
      b = req_in2[u][idx*8 +: 8];
      e.id   = idx;
      e.prod = 16'(a) * 16'(b);
      sb.push_back(e);
    end
  endtask

  task automatic wait_accept(input int u, input int bound, output int idx, output int waited);
    idx = -1;
    waited = 0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      waited++;
      if (|(req_valid[u] & req_ready[u])) begin
        push_accept(u, idx);
        break;
      end
    end
  endtask

  // Counts negedges from the accept cycle until resp_valid shows.
  task automatic wait_resp(input int u, output int lat);
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      lat++;
      if (resp_valid[u]) break;
    end
  endtask

  task automatic pop_check(input int u, input logic [15:0] exp_prod, input string nm);
    sb_t e;
    if (sb.size() == 0) begin
      check({nm, " sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({nm, " id"}, 32'(resp_id[u]), 32'(e.id));
      check({nm, " out"}, 32'(resp_out[u]), 32'(e.prod));
      check({nm, " table"}, 32'(resp_out[u]), 32'(exp_prod));
    end
  endtask

  task automatic do_op(input int u, input int cc, input int exp_id, input logic [15:0] exp_prod,
                       input bit drop, input string nm, output int waited);
    int idx, lat;
    wait_accept(u, 30, idx, waited);
    check({nm, " grant"}, 32'(idx), 32'(exp_id));
    if (idx < 0) return;
    if (drop) begin
      @(posedge clk); #1;
      req_valid[u] = 2'b00;
    end
    wait_resp(u, lat);
    check({nm, " latency"}, 32'(lat), 32'(1 + cc));
    if (resp_valid[u]) pop_check(u, exp_prod, nm);
  endtask

  initial begin
    int idx, waited, lat, stale;
    int exp_order[4];

    vt[0] = '{2'b01, 8'd13,  8'd11,  8'd0,   8'd0,   0, 16'd143};
    vt[1] = '{2'b01, 8'd255, 8'd255, 8'd0,   8'd0,   0, 16'd65025};
    vt[2] = '{2'b01, 8'd0,   8'd200, 8'd0,   8'd0,   0, 16'd0};
    vt[3] = '{2'b10, 8'd0,   8'd0,   8'd7,   8'd9,   1, 16'd63};
    vt[4] = '{2'b10, 8'd0,   8'd0,   8'd200, 8'd255, 1, 16'd51000};
    vt[5] = '{2'b11, 8'd12,  8'd12,  8'd5,   8'd5,   0, 16'd144};
`ifdef MUL_SHARE_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif

    for (int u = 0; u < 3; u++) begin
      rst_n[u] = 1'b0; req_valid[u] = '0; req_in1[u] = '0; req_in2[u] = '0;
      resp_ready[u] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check("rst resp_valid", 32'(resp_valid[u]), 32'd0);
      check("rst busy", 32'(busy[u]), 32'd0);
      check("rst resp_out", 32'(resp_out[u]), 32'd0);
      check("rst resp_id", 32'(resp_id[u]), 32'd0);
      check("rst req_ready", 32'(req_ready[u]), 32'd0);
    end
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;

    for (int v = 0; v < 6; v++) begin
      req_in1[0]   = {vt[v].a1, vt[v].a0};
      req_in2[0]   = {vt[v].b1, vt[v].b0};
      req_valid[0] = vt[v].valid;
      do_op(0, 1, vt[v].exp_id, vt[v].exp_prod, 1'b1, $sformatf("vec%0d", v), waited);
      @(posedge clk); #1;
    end

    // Backpressure: response held for 5 cycles, pending request not granted.
    resp_ready[0] = 1'b0;
    req_in1[0] = {8'd0, 8'd3};
    req_in2[0] = {8'd0, 8'd5};
    req_valid[0] = 2'b01;
    wait_accept(0, 20, idx, waited);
    check("bp grant", 32'(idx), 32'd0);
    @(posedge clk); #1;
    req_in1[0] = {8'd0, 8'd6};
    req_in2[0] = {8'd0, 8'd7};
    wait_resp(0, lat);
    check("bp latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp hold valid", 32'(resp_valid[0]), 32'd1);
      check("bp hold out", 32'(resp_out[0]), 32'd15);
      check("bp hold id", 32'(resp_id[0]), 32'd0);
      check("bp hold ready", 32'(req_ready[0]), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp release ready", 32'(req_ready[0]), 32'd0);
    check("bp release valid", 32'(resp_valid[0]), 32'd1);
    pop_check(0, 16'd15, "bp first");
    @(negedge clk);
    check("bp reaccept", 32'(req_ready[0]), 32'd1);
    push_accept(0, idx);
    @(posedge clk); #1;
    req_valid[0] = 2'b00;
    wait_resp(0, lat);
    check("bp2 latency", 32'(lat), 32'd2);
    pop_check(0, 16'd42, "bp second");

    // Multicycle path with CALC_CYCLES=3.
    req_in1[1] = {8'd0, 8'd200};
    req_in2[1] = {8'd0, 8'd3};
    req_valid[1] = 2'b01;
    do_op(1, 3, 0, 16'd600, 1'b1, "mcyc", waited);

    // Reset on the 2nd CALC cycle with CALC_CYCLES=4.
    req_in1[2] = {8'd0, 8'd9};
    req_in2[2] = {8'd0, 8'd9};
    req_valid[2] = 2'b01;
    wait_accept(2, 20, idx, waited);
    check("rstcalc grant", 32'(idx), 32'd0);
    @(posedge clk); #1;
    req_valid[2] = 2'b00;
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    @(negedge clk);
    check("rstcalc busy before", 32'(busy[2]), 32'd1);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rstcalc busy", 32'(busy[2]), 32'd0);
    check("rstcalc resp_valid", 32'(resp_valid[2]), 32'd0);
    check("rstcalc resp_out", 32'(resp_out[2]), 32'd0);
    check("rstcalc resp_id", 32'(resp_id[2]), 32'd0);
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (resp_valid[2] || busy[2]) stale++;
    end
    check("rstcalc no stale", 32'(stale), 32'd0);

    // Contention: both requesters valid continuously for 4 operations.
    req_in1[2] = {8'd4, 8'd3};
    req_in2[2] = {8'd6, 8'd5};
    @(posedge clk); #1;
    req_valid[2] = 2'b11;
    for (int n = 0; n < 4; n++) begin
      do_op(2, 4, exp_order[n], (exp_order[n] == 0) ? 16'd15 : 16'd24, 1'b0,
            $sformatf("cont%0d", n), waited);
      check($sformatf("cont%0d spacing", n), 32'(waited), 32'd1);
    end
    @(posedge clk); #1;
    req_valid[2] = 2'b00;
    repeat (2) @(negedge clk);
    check("cont idle", 32'(busy[2]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
